adc_scan_sequencer: RTL and testbench

//  Sequences a multi-channel ADC front-end: walks an enabled-channel mask, issues one conversion per channel,

---
 rtl/adc_scan_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - multi-channel ADC scan sequencer with Avalon-MM register bank
module adc_scan_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              adc_start,
  output logic [2:0]        adc_ch,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              irq
);

  localparam int TC_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_CONV, S_NEXT, S_WAIT} state_t;

  state_t state, state_n;

  logic                enable, single_shot, irq_en;
  logic [NUM_CH-1:0]   mask;
  logic [PERIOD_W-1:0] period, pcnt;
  logic [TC_W-1:0]     tcnt;
  logic [2:0]          ch, ch_n;
  logic                round_done, timeout_flag;
  logic [NUM_CH-1:0]   res_valid;
  logic [DATA_W-1:0]   res_data [NUM_CH];
  logic [2:0]          res_ch   [NUM_CH];
  logic [31:0]         rdata_n;

  logic start_c, tcnt_clr, tcnt_inc, store, set_to, set_rd, clr_en, pcnt_load, pcnt_dec;
  logic [3:0] low_sel, nxt_sel;

  logic wr, wr_ctrl, wr_mask, wr_period, wr_status;
  logic unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 4'd0);
  assign wr_mask   = wr && (address == 4'd1);
  assign wr_period = wr && (address == 4'd2);
  assign wr_status = wr && (address == 4'd3);
  assign unused_wdata = &{1'b0, writedata[31:PERIOD_W]};

  // {found, channel} of the lowest enabled channel
  function automatic logic [3:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [3:0] r;
    r = 4'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  // {found, channel} of the lowest enabled channel strictly above cur
  function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    return r;
  endfunction

  assign low_sel   = lowest_ch(mask);
  assign nxt_sel   = next_ch(mask, ch);
  // adc_start decodes straight from the state so an async reset drops it immediately
  assign adc_start = start_c;
  assign adc_ch    = ch;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    start_c   = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    store     = 1'b0;
    set_to    = 1'b0;
    set_rd    = 1'b0;
    clr_en    = 1'b0;
    pcnt_load = 1'b0;
    pcnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && low_sel[3]) begin
          ch_n    = low_sel[2:0];
          state_n = S_START;
        end
      end
      S_START: begin
        start_c  = 1'b1;
        tcnt_clr = 1'b1;
        state_n  = S_CONV;
      end
      S_CONV: begin
        if (adc_done) begin
          store   = 1'b1;
          state_n = S_NEXT;
        end else if (tcnt == TC_W'(TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_n = S_NEXT;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_NEXT: begin
        if (nxt_sel[3]) begin
          // a disabled sequencer finishes only the conversion already in flight
          if (enable) begin
            ch_n    = nxt_sel[2:0];
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          set_rd = 1'b1;
          if (single_shot) begin
            clr_en  = 1'b1;
            state_n = S_IDLE;
          end else if (!enable) begin
            state_n = S_IDLE;
          end else begin
            pcnt_load = 1'b1;
            state_n   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!enable || !low_sel[3]) begin
          state_n = S_IDLE;
        end else if (pcnt == '0) begin
          ch_n    = low_sel[2:0];
          state_n = S_START;
        end else begin
          pcnt_dec = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Channel pointer, conversion timeout counter and inter-round period counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch   <= 3'd0;
      tcnt <= '0;
      pcnt <= '0;
    end else begin
      ch <= ch_n;
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
      if (pcnt_load)     pcnt <= period;
      else if (pcnt_dec) pcnt <= pcnt - 1'b1;
    end
  end

  // Software-visible control/status registers; hardware set beats a W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable       <= 1'b0;
      single_shot  <= 1'b0;
      irq_en       <= 1'b0;
      mask         <= '0;
      period       <= '0;
      round_done   <= 1'b0;
      timeout_flag <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable      <= writedata[0];
        single_shot <= writedata[1];
        irq_en      <= writedata[2];
      end else if (clr_en) begin
        enable <= 1'b0;
      end
      if (wr_mask)   mask   <= writedata[NUM_CH-1:0];
      if (wr_period) period <= writedata[PERIOD_W-1:0];
      round_done   <= set_rd | (round_done & ~(wr_status & writedata[1]));
      timeout_flag <= set_to | (timeout_flag & ~(wr_status & writedata[2]));
      irq          <= irq_en & (round_done | timeout_flag);
    end
  end

  // Per-channel result registers; a CTRL write invalidates, a same-cycle store still lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        res_data[n] <= '0;
        res_ch[n]   <= 3'd0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (store && (ch == 3'(n))) begin
          res_valid[n] <= 1'b1;
          res_data[n]  <= adc_data;
          res_ch[n]    <= ch;
        end else if (wr_ctrl) begin
          res_valid[n] <= 1'b0;
        end
      end
    end
  end

  // Read mux
  always_comb begin
    rdata_n = 32'd0;
    case (address)
      4'd0: rdata_n[2:0] = {irq_en, single_shot, enable};
      4'd1: rdata_n[NUM_CH-1:0] = mask;
      4'd2: rdata_n[PERIOD_W-1:0] = period;
      4'd3: begin
        rdata_n[0]    = (state != S_IDLE);
        rdata_n[1]    = round_done;
        rdata_n[2]    = timeout_flag;
        rdata_n[10:8] = ch;
      end
      default: begin
        if (address[3] && (int'(address[2:0]) < NUM_CH)) begin
          rdata_n[31]          = res_valid[address[2:0]];
          rdata_n[18:16]       = res_ch[address[2:0]];
          rdata_n[DATA_W-1:0]  = res_data[address[2:0]];
        end
      end
    endcase
  end

  // Registered read data, one cycle behind the address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 32'd0;
    else          readdata <= rdata_n;
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        irq;

  adc_scan_sequencer #(.NUM_CH(8), .DATA_W(12), .PERIOD_W(24), .TIMEOUT(4096)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done),
    .adc_data(adc_data), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Scan model: channels visited in ascending order of the mask, wrapping per round
  logic [7:0]  m_mask = 8'h00;
  int          m_last = -1;
  logic        exp_valid [8];
  logic [11:0] exp_data  [8];
  int          n_starts = 0;
  logic        outstanding = 1'b0;
  logic [2:0]  out_ch = 3'd0;
  int          age = 0;
  logic        prev_start = 1'b0;

  // ADC responder settings
  logic        adc_auto = 1'b0;
  int          adc_delay = 0;
  logic [11:0] sample_seq = 12'h123;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic int model_next(input logic [7:0] m, input int last);
    for (int i = last + 1; i < 8; i++) if (m[i]) return i;
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the scan model and conversion bookkeeping
  always @(negedge clk) begin
    if (!reset_n) begin
      outstanding = 1'b0;
      prev_start  = 1'b0;
    end else begin
      if (adc_start) begin
        int e;
        e = model_next(m_mask, m_last);
        check("start_single_pulse", 32'(prev_start), 32'd0);
        check("start_channel", 32'(adc_ch), 32'(e));
        m_last = e;
        n_starts++;
        outstanding = 1'b1;
        out_ch = 3'(e);
        age = 0;
      end else if (outstanding) begin
        age++;
        check("ch_held", 32'(adc_ch), 32'(out_ch));
        if (adc_done) begin
          exp_valid[out_ch] = 1'b1;
          exp_data[out_ch]  = adc_data;
          outstanding = 1'b0;
        end else if (age >= 4096) begin
          outstanding = 1'b0;
        end
      end
      prev_start = adc_start;
    end
  end

  // ADC front-end model: done pulse a fixed number of cycles after start (0 = never)
  initial forever begin
    @(negedge clk);
    if (adc_start && adc_auto && adc_delay > 0) begin
      repeat (adc_delay) @(posedge clk);
      #1;
      adc_done = 1'b1;
      adc_data = sample_seq;
      sample_seq = sample_seq + 12'h111;
      @(posedge clk);
      #1;
      adc_done = 1'b0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    @(posedge clk);
    #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = v;
    if (a == 4'd0) for (int i = 0; i < 8; i++) exp_valid[i] = 1'b0;
    if (a == 4'd1) m_mask = v[7:0];
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    address = a;
    @(posedge clk);
    #1;
    d = readdata;
  endtask

  task automatic wait_start(input int limit, input string name, output int at_cyc);
    int n;
    at_cyc = -1;
    n = 0;
    while (n < limit && at_cyc < 0) begin
      @(negedge clk);
      if (adc_start) at_cyc = cyc;
      n++;
    end
    if (at_cyc < 0) bound_expired(name);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    int n;
    n = 0;
    rd(4'd3, d);
    while (d[0] && n < 100) begin
      rd(4'd3, d);
      n++;
    end
    check(name, 32'(d[0]), 32'd0);
  endtask

  task automatic check_res(input int n, input string name);
    logic [31:0] d;
    rd(4'(8 + n), d);
    if (exp_valid[n]) check(name, d, 32'h8000_0000 | (32'(n) << 16) | 32'(exp_data[n]));
    else              check(name, 32'(d[31]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int s0, s2, s0b, s1, t1, t2, k;

    for (int i = 0; i < 8; i++) begin exp_valid[i] = 1'b0; exp_data[i] = 12'h0; end
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = 32'd0;
    adc_done = 1'b0; adc_data = 12'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_adc_ch", 32'(adc_ch), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    rd(4'd0, d); check("rst_ctrl", d, 32'd0);
    rd(4'd3, d); check("rst_status", d, 32'd0);
    rd(4'd8, d); check("rst_res0", d, 32'd0);

    // Scenario 1: two-channel periodic scan with irq
    wr(4'd1, 32'h05); wr(4'd2, 32'd10);
    m_last = -1; adc_auto = 1'b1; adc_delay = 20;
    wr(4'd0, 32'h5);
    wait_start(20, "t1_start_ch0", s0);
    wait_start(60, "t1_start_ch2", s2);
    wait_start(80, "t1_start_round2", s0b);
    // done 20 cycles after start, one NEXT cycle, then START
    check("t1_gap_ch0_ch2", 32'(s2 - s0), 32'd22);
    // done +20, NEXT +21, 11 WAIT cycles for PERIOD=10, START +33
    check("t1_gap_round", 32'(s0b - s2), 32'd33);
    rd(4'd3, d); check("t1_status", d, 32'h3);
    check("t1_irq", 32'(irq), 32'd1);
    check_res(0, "t1_res0");
    check_res(2, "t1_res2");
    check_res(1, "t1_res1_invalid");
    rd(4'd5, d); check("t1_unmapped", d, 32'd0);
    rd(4'd2, d); check("t1_period", d, 32'd10);
    rd(4'd1, d); check("t1_mask", d, 32'h05);
    wr(4'd0, 32'h0);
    wait_idle("t1_idle");

    // Scenario 5: W1C coinciding with round_done set
    wr(4'd3, 32'h6);
    wr(4'd1, 32'h01); wr(4'd2, 32'd0);
    m_last = -1; adc_auto = 1'b0;
    wr(4'd0, 32'h5);
    wait_start(20, "t5_start", t1);
    repeat (3) @(posedge clk);
    #1; adc_done = 1'b1; adc_data = 12'h5A5;
    @(posedge clk);
    #1; adc_done = 1'b0;
    chipselect = 1'b1; write_n = 1'b0; address = 4'd3; writedata = 32'h2;
    @(posedge clk);
    #1; chipselect = 1'b0; write_n = 1'b1;
    rd(4'd3, d); check("t5_set_wins", d, 32'h3);
    check("t5_irq_set", 32'(irq), 32'd1);
    rd(4'd8, d); check("t5_res0", d, 32'h8000_05A5);
    wr(4'd3, 32'h2);
    rd(4'd3, d); check("t5_w1c", d, 32'h1);
    @(posedge clk);
    #1; check("t5_irq_drop", 32'(irq), 32'd0);
    wr(4'd0, 32'h0);
    @(posedge clk);
    #1; adc_done = 1'b1; adc_data = 12'h0F0;
    @(posedge clk);
    #1; adc_done = 1'b0;
    wait_idle("t5_idle");

    // Scenario 4: disable mid-conversion on ch1
    wr(4'd3, 32'h6);
    wr(4'd1, 32'h0F); wr(4'd2, 32'd0);
    m_last = -1; adc_auto = 1'b1; adc_delay = 20;
    wr(4'd0, 32'h1);
    wait_start(20, "t4_start_ch0", t1);
    wait_start(60, "t4_start_ch1", s1);
    repeat (4) @(posedge clk);
    k = n_starts;
    wr(4'd0, 32'h0);
    repeat (60) @(posedge clk);
    check("t4_no_more_starts", 32'(n_starts), 32'(k));
    rd(4'd3, d); check("t4_busy", 32'(d[0]), 32'd0);
    rd(4'd9, d); check("t4_res1_valid", 32'(d[31]), 32'd1);
    check_res(1, "t4_res1");
    check_res(0, "t4_res0_cleared");

    // Scenario 2: single-shot on the top channel
    wr(4'd3, 32'h6);
    wr(4'd1, 32'h80);
    m_last = -1;
    k = n_starts;
    wr(4'd0, 32'h3);
    wait_start(20, "t2_start", t1);
    repeat (80) @(posedge clk);
    check("t2_one_start", 32'(n_starts), 32'(k + 1));
    rd(4'd0, d); check("t2_ctrl", d, 32'h2);
    rd(4'd3, d); check("t2_status", d, 32'h702);
    check_res(7, "t2_res7");
    check("t2_irq", 32'(irq), 32'd0);

    // Scenario 3: conversion timeout
    wr(4'd3, 32'h6);
    wr(4'd1, 32'h01); wr(4'd2, 32'd0);
    m_last = -1; adc_delay = 0;
    wr(4'd0, 32'h1);
    wait_start(20, "t3_start", t1);
    repeat (100) @(posedge clk);
    rd(4'd3, d); check("t3_no_timeout_yet", d, 32'h1);
    wait_start(5000, "t3_restart", t2);
    // 4096 CONV cycles, NEXT, one WAIT cycle, START
    check("t3_gap", 32'(t2 - t1), 32'd4099);
    rd(4'd3, d); check("t3_status", d, 32'h7);
    check_res(0, "t3_res0_invalid");
    check("t3_irq", 32'(irq), 32'd0);

    // Scenario 6: reset during CONV
    rd(4'd3, d);
    @(negedge clk);
    check("t6_pre_readdata", readdata, 32'h7);
    reset_n = 1'b0;
    #1;
    check("t6_adc_start", 32'(adc_start), 32'd0);
    check("t6_adc_ch", 32'(adc_ch), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    check("t6_readdata", readdata, 32'd0);
    @(posedge clk);
    #1; reset_n = 1'b1;
    m_mask = 8'h00; m_last = -1;
    for (int i = 0; i < 8; i++) exp_valid[i] = 1'b0;
    k = n_starts;
    repeat (60) @(posedge clk);
    check("t6_quiet", 32'(n_starts), 32'(k));
    rd(4'd0, d); check("t6_ctrl", d, 32'd0);
    rd(4'd1, d); check("t6_mask", d, 32'd0);
    rd(4'd3, d); check("t6_status", d, 32'd0);

    // Reset landing on the START cycle drops adc_start without a clock edge
    adc_delay = 20;
    wr(4'd1, 32'h08);
    m_last = -1;
    wr(4'd0, 32'h5);
    t1 = -1;
    for (int n = 0; n < 20 && t1 < 0; n++) begin
      @(negedge clk);
      if (adc_start) t1 = cyc;
    end
    if (t1 < 0) bound_expired("t6b_start");
    reset_n = 1'b0;
    #1;
    check("t6b_adc_start", 32'(adc_start), 32'd0);
    check("t6b_adc_ch", 32'(adc_ch), 32'd0);
    repeat (30) @(posedge clk);
    #1; reset_n = 1'b1;
    m_mask = 8'h00; m_last = -1;
    k = n_starts;
    repeat (40) @(posedge clk);
    check("t6b_quiet", 32'(n_starts), 32'(k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
